// File: rtl/gauss_pkg.sv
// Shared definitions for the Gaussian frame sequencer: FSM states and kernel-size decoding.
package gauss_pkg;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_ISSUE   = 3'd1,
      S_PRESENT = 3'd2,
      S_WAIT    = 3'd3,
      S_WRITE   = 3'd4,
      S_DONE    = 3'd5
   } state_e;

   localparam logic [2:0] KSIZE_3 = 3'd3;
   localparam logic [2:0] KSIZE_5 = 3'd5;
   localparam logic [2:0] KSIZE_7 = 3'd7;

   // The reserved selector value falls back to the smallest kernel.
   function automatic logic [2:0] ksize_decode(input logic [1:0] sel);
      logic [2:0] k;
      case (sel)
         2'd1:    k = KSIZE_5;
         2'd2:    k = KSIZE_7;
         default: k = KSIZE_3;
      endcase
      return k;
   endfunction

endpackage

// File: rtl/gauss_win_addr.sv
// Window tap locator: bounds check of (r+ky-half, c+kx-half) and interleaved frame address.
module gauss_win_addr
   import gauss_pkg::*;
#(
   parameter int ROWS   = 192,
   parameter int COLS   = 192,
   parameter int CH     = 3,
   parameter int ADDR_W = $clog2(ROWS * COLS * CH)
) (
   input  logic [ADDR_W-1:0] r,
   input  logic [ADDR_W-1:0] c,
   input  logic [ADDR_W-1:0] ch,
   input  logic [2:0]        ky,
   input  logic [2:0]        kx,
   input  logic [1:0]        half,
   output logic              in_bounds,
   output logic [ADDR_W-1:0] addr
);

   localparam logic signed [ADDR_W:0] ROWS_S = (ADDR_W+1)'(ROWS);
   localparam logic signed [ADDR_W:0] COLS_S = (ADDR_W+1)'(COLS);
   localparam logic [ADDR_W-1:0]      COLS_A = ADDR_W'(COLS);
   localparam logic [ADDR_W-1:0]      CH_A   = ADDR_W'(CH);

   logic signed [ADDR_W:0] pr_s;
   logic signed [ADDR_W:0] pc_s;

   // Signed window position; the multiply only feeds the address for in-frame taps.
   always_comb begin
      pr_s = $signed((ADDR_W+1)'(r)) + $signed((ADDR_W+1)'(ky)) - $signed((ADDR_W+1)'(half));
      pc_s = $signed((ADDR_W+1)'(c)) + $signed((ADDR_W+1)'(kx)) - $signed((ADDR_W+1)'(half));
      in_bounds = !pr_s[ADDR_W] && (pr_s < ROWS_S) && !pc_s[ADDR_W] && (pc_s < COLS_S);
      if (in_bounds) begin
         addr = (pr_s[ADDR_W-1:0] * COLS_A + pc_s[ADDR_W-1:0]) * CH_A + ch;
      end else begin
         addr = '0;
      end
   end

endmodule

// File: rtl/gauss_frame_sequencer.sv
// Walks every (row, col, channel) sample of a frame, streams its zero-padded kernel window
// to the convolution core one tap at a time and writes the core's result back out.
module gauss_frame_sequencer
   import gauss_pkg::*;
#(
   parameter int ROWS   = 192,
   parameter int COLS   = 192,
   parameter int CH     = 3,
   parameter int SIZE   = ROWS * COLS * CH,
   parameter int ADDR_W = $clog2(SIZE)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [1:0]        ksize_sel,
   output logic              busy,
   output logic              done,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [7:0]        rd_data,
   output logic              tap_valid,
   output logic [7:0]        tap_pix,
   output logic [5:0]        tap_idx,
   output logic              tap_last,
   input  logic              tap_ready,
   input  logic              res_valid,
   input  logic [7:0]        res_data,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [7:0]        wr_data
);

   localparam logic [ADDR_W-1:0] ROWS_M1 = ADDR_W'(ROWS - 1);
   localparam logic [ADDR_W-1:0] COLS_M1 = ADDR_W'(COLS - 1);
   localparam logic [ADDR_W-1:0] CH_M1   = ADDR_W'(CH - 1);
   localparam logic [ADDR_W-1:0] COLS_A  = ADDR_W'(COLS);
   localparam logic [ADDR_W-1:0] CH_A    = ADDR_W'(CH);
   localparam logic [ADDR_W-1:0] ONE_A   = ADDR_W'(1);

   state_e            state_q, state_d;
   logic [2:0]        k_q, k_d, ky_q, ky_d, kx_q, kx_d;
   logic [1:0]        half_q, half_d;
   logic [ADDR_W-1:0] r_q, r_d, c_q, c_d, ch_q, ch_d;
   logic              pad_q, pad_d, phase_q, phase_d;
   logic              busy_q, busy_d, done_q, done_d, rd_en_q, rd_en_d;
   logic [ADDR_W-1:0] rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
   logic              tap_valid_q, tap_valid_d, tap_last_q, tap_last_d, wr_en_q, wr_en_d;
   logic [7:0]        tap_pix_q, tap_pix_d, wr_data_q, wr_data_d;
   logic [5:0]        tap_idx_q, tap_idx_d;
   logic              in_bounds_s, last_sample_s;
   logic [ADDR_W-1:0] win_addr_s, out_addr_s;

   gauss_win_addr #(.ROWS(ROWS), .COLS(COLS), .CH(CH), .ADDR_W(ADDR_W)) u_win_addr (
      .r(r_q), .c(c_q), .ch(ch_q), .ky(ky_q), .kx(kx_q), .half(half_q),
      .in_bounds(in_bounds_s), .addr(win_addr_s)
   );

   // Next-state and next-output logic for the frame walk.
   always_comb begin
      state_d     = state_q;     k_d = k_q;       half_d = half_q;
      r_d         = r_q;         c_d = c_q;       ch_d   = ch_q;
      ky_d        = ky_q;        kx_d = kx_q;     pad_d  = pad_q;   phase_d = phase_q;
      busy_d      = busy_q;      done_d = 1'b0;   rd_en_d = 1'b0;   rd_addr_d = rd_addr_q;
      tap_valid_d = tap_valid_q; tap_pix_d = tap_pix_q; tap_idx_d = tap_idx_q;
      tap_last_d  = tap_last_q;  wr_en_d = 1'b0;  wr_addr_d = wr_addr_q; wr_data_d = wr_data_q;
      out_addr_s    = (r_q * COLS_A + c_q) * CH_A + ch_q;
      last_sample_s = (ch_q == CH_M1) && (c_q == COLS_M1) && (r_q == ROWS_M1);
      case (state_q)
         S_IDLE: begin
            if (start) begin
               k_d     = ksize_decode(ksize_sel);
               half_d  = k_d[2:1];
               r_d     = '0;  c_d  = '0;  ch_d = '0;
               ky_d    = 3'd0; kx_d = 3'd0;
               busy_d  = 1'b1;
               state_d = S_ISSUE;
            end else begin
               busy_d  = 1'b0;
            end
         end
         S_ISSUE: begin
            rd_en_d = in_bounds_s;
            pad_d   = !in_bounds_s;
            phase_d = 1'b0;
            if (in_bounds_s) begin
               rd_addr_d = win_addr_s;
            end else begin
               rd_addr_d = rd_addr_q;
            end
            state_d = S_PRESENT;
         end
         S_PRESENT: begin
            // phase 0 is the read cycle; read data is valid on phase 1 and captured then
            if (!tap_valid_q) begin
               if (!phase_q) begin
                  phase_d = 1'b1;
               end else begin
                  tap_valid_d = 1'b1;
                  tap_pix_d   = pad_q ? 8'd0 : rd_data;
                  tap_idx_d   = {3'd0, ky_q} * {3'd0, k_q} + {3'd0, kx_q};
                  tap_last_d  = (ky_q == k_q - 3'd1) && (kx_q == k_q - 3'd1);
               end
            end else if (tap_ready) begin
               tap_valid_d = 1'b0;
               if (tap_last_q) begin
                  kx_d    = 3'd0;
                  ky_d    = 3'd0;
                  state_d = S_WAIT;
               end else if (kx_q == k_q - 3'd1) begin
                  kx_d    = 3'd0;
                  ky_d    = ky_q + 3'd1;
                  state_d = S_ISSUE;
               end else begin
                  kx_d    = kx_q + 3'd1;
                  state_d = S_ISSUE;
               end
            end else begin
               tap_valid_d = 1'b1;
            end
         end
         S_WAIT: begin
            if (res_valid) begin
               wr_data_d = res_data;
               wr_addr_d = out_addr_s;
               wr_en_d   = 1'b1;
               state_d   = S_WRITE;
            end else begin
               state_d   = S_WAIT;
            end
         end
         S_WRITE: begin
            if (last_sample_s) begin
               r_d = '0; c_d = '0; ch_d = '0;
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = S_DONE;
            end else if (ch_q != CH_M1) begin
               ch_d    = ch_q + ONE_A;
               state_d = S_ISSUE;
            end else if (c_q != COLS_M1) begin
               ch_d    = '0;
               c_d     = c_q + ONE_A;
               state_d = S_ISSUE;
            end else begin
               ch_d    = '0;
               c_d     = '0;
               r_d     = r_q + ONE_A;
               state_d = S_ISSUE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State, counter and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;  k_q <= 3'd0;  half_q <= 2'd0;
         r_q <= '0;  c_q <= '0;  ch_q <= '0;  ky_q <= 3'd0;  kx_q <= 3'd0;
         pad_q <= 1'b0;  phase_q <= 1'b0;  busy_q <= 1'b0;  done_q <= 1'b0;
         rd_en_q <= 1'b0;  rd_addr_q <= '0;  tap_valid_q <= 1'b0;  tap_pix_q <= 8'd0;
         tap_idx_q <= 6'd0;  tap_last_q <= 1'b0;  wr_en_q <= 1'b0;  wr_addr_q <= '0;
         wr_data_q <= 8'd0;
      end else begin
         state_q <= state_d;  k_q <= k_d;  half_q <= half_d;
         r_q <= r_d;  c_q <= c_d;  ch_q <= ch_d;  ky_q <= ky_d;  kx_q <= kx_d;
         pad_q <= pad_d;  phase_q <= phase_d;  busy_q <= busy_d;  done_q <= done_d;
         rd_en_q <= rd_en_d;  rd_addr_q <= rd_addr_d;  tap_valid_q <= tap_valid_d;
         tap_pix_q <= tap_pix_d;  tap_idx_q <= tap_idx_d;  tap_last_q <= tap_last_d;
         wr_en_q <= wr_en_d;  wr_addr_q <= wr_addr_d;  wr_data_q <= wr_data_d;
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign rd_en     = rd_en_q;
   assign rd_addr   = rd_addr_q;
   assign tap_valid = tap_valid_q;
   assign tap_pix   = tap_pix_q;
   assign tap_idx   = tap_idx_q;
   assign tap_last  = tap_last_q;
   assign wr_en     = wr_en_q;
   assign wr_addr   = wr_addr_q;
   assign wr_data   = wr_data_q;

endmodule

// File: tb/tb_gauss_frame_sequencer.sv
// Directed bench for gauss_frame_sequencer on a 4x4 RGB frame whose memory holds addr & 8'hFF;
// the core model answers each window with its tap count.
module tb_gauss_frame_sequencer;

   logic       clk = 1'b0, rst = 1'b1, start = 1'b0;
   logic [1:0] ksize_sel = 2'd0;
   logic       busy, done, rd_en, tap_valid, tap_last, wr_en;
   logic [5:0] rd_addr, wr_addr, tap_idx;
   logic [7:0] rd_data = 8'd0, tap_pix, wr_data, res_data = 8'd0;
   logic       tap_ready = 1'b1, res_valid = 1'b0;

   gauss_frame_sequencer #(.ROWS(4), .COLS(4), .CH(3)) dut (
      .clk(clk), .rst(rst), .start(start), .ksize_sel(ksize_sel), .busy(busy), .done(done),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .tap_valid(tap_valid),
      .tap_pix(tap_pix), .tap_idx(tap_idx), .tap_last(tap_last), .tap_ready(tap_ready),
      .res_valid(res_valid), .res_data(res_data), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_data(wr_data)
   );

   always #5 clk = ~clk;

   // Frame memory: one-cycle read latency, contents addr & 8'hFF.
   always @(posedge clk) if (rd_en) rd_data <= 8'(rd_addr);

   int n_chk = 0, n_pass = 0;
   int cyc = 0, done_cnt = 0, done_cyc = 0, last_wr_cyc = 0;
   logic busy_at_done = 1'b0;
   int tp_pix[$], tp_idx[$], tp_last[$], tp_rd[$], wr_a[$], wr_d[$];
   int rd_pend = 0, rd_pend_addr = 0, extra_rd = 0;
   int stall_idx = -1, stall_left = 0, stall_seen = 0, stab_err = 0;
   logic [15:0] stall_snap = 16'd0;
   int resp_cnt = 0, resp_val = 0, win_taps = 0, stray_arm = 0, stray_cnt = 0;
   int rst_arm = -1, rst_trig = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   // Core model and monitor, all sampled on the falling edge.
   initial begin
      forever begin
         @(negedge clk);
         cyc++;
         if (stall_idx >= 0 && tap_valid && int'(tap_idx) == stall_idx) begin
            stall_idx  = -1;
            stall_left = 5;
            stall_snap = {tap_valid, tap_pix, tap_idx, tap_last};
         end
         if (stall_left > 0) begin
            tap_ready = 1'b0;
            stall_left--;
            stall_seen++;
            if ({tap_valid, tap_pix, tap_idx, tap_last} !== stall_snap) stab_err++;
         end else tap_ready = 1'b1;
         res_valid = 1'b0;
         if (resp_cnt > 0) begin
            resp_cnt--;
            if (resp_cnt == 0) begin res_valid = 1'b1; res_data = 8'(resp_val); end
         end
         if (stray_cnt > 0) begin
            stray_cnt--;
            if (stray_cnt == 0) begin res_valid = 1'b1; res_data = 8'hEE; end
         end
         if (rd_en) begin
            if (rd_pend != 0) extra_rd++;
            rd_pend = 1;
            rd_pend_addr = int'(rd_addr);
         end
         if (tap_valid && tap_ready) begin
            tp_pix.push_back(int'(tap_pix));
            tp_idx.push_back(int'(tap_idx));
            tp_last.push_back(int'(tap_last));
            tp_rd.push_back(rd_pend != 0 ? rd_pend_addr : -1);
            rd_pend = 0;
            win_taps++;
            if (tap_last) begin
               resp_cnt = 2;
               resp_val = win_taps;
               win_taps = 0;
               if (rst_arm == wr_a.size()) rst_trig = 1;
            end else if (stray_arm != 0) begin
               stray_arm = 0;
               stray_cnt = 1;
            end
         end
         if (wr_en) begin wr_a.push_back(int'(wr_addr)); wr_d.push_back(int'(wr_data)); last_wr_cyc = cyc; end
         if (done) begin done_cnt++; done_cyc = cyc; busy_at_done = busy; end
      end
   end

   task automatic check_zero(input string tag);
      chk({tag, "_busy"}, busy, 0);        chk({tag, "_done"}, done, 0);
      chk({tag, "_rd_en"}, rd_en, 0);      chk({tag, "_rd_addr"}, rd_addr, 0);
      chk({tag, "_tap_valid"}, tap_valid, 0); chk({tag, "_tap_pix"}, tap_pix, 0);
      chk({tag, "_tap_idx"}, tap_idx, 0);  chk({tag, "_tap_last"}, tap_last, 0);
      chk({tag, "_wr_en"}, wr_en, 0);      chk({tag, "_wr_addr"}, wr_addr, 0);
      chk({tag, "_wr_data"}, wr_data, 0);
   endtask

   task automatic start_frame(input logic [1:0] sel);
      tp_pix.delete(); tp_idx.delete(); tp_last.delete(); tp_rd.delete();
      wr_a.delete(); wr_d.delete();
      rd_pend = 0; extra_rd = 0; stab_err = 0; stall_seen = 0; win_taps = 0;
      @(negedge clk);
      ksize_sel = sel; start = 1'b1;
      @(negedge clk);
      start = 1'b0; ksize_sel = 2'd3;
      chk("busy_after_start", busy, 1);
   endtask

   task automatic wait_done(input string tag, input int budget);
      int d0 = done_cnt;
      int i = 0;
      while (done_cnt == d0 && i < budget) begin @(negedge clk); i++; end
      chk({tag, "_done_seen"}, done_cnt - d0, 1);
   endtask

   // Expected window contents come from the tap position formula on the 4x4x3 frame.
   task automatic verify_frame(input string tag, input int k);
      int h = k / 2, errs = 0, werr = 0;
      for (int s = 0; s < 48; s++) begin
         for (int t = 0; t < k * k; t++) begin
            int n  = s * k * k + t;
            int rr = s / 12 + t / k - h;
            int cc = (s / 3) % 4 + t % k - h;
            int ea = (rr >= 0 && rr < 4 && cc >= 0 && cc < 4) ? (rr * 4 + cc) * 3 + s % 3 : -1;
            if (n >= tp_rd.size()) errs++;
            else if (tp_rd[n] != ea || tp_pix[n] != (ea < 0 ? 0 : ea & 255) ||
                     tp_idx[n] != t || tp_last[n] != ((t == k * k - 1) ? 1 : 0)) errs++;
         end
      end
      for (int i = 0; i < wr_a.size(); i++) if (wr_a[i] != i || wr_d[i] != k * k) werr++;
      chk({tag, "_tap_count"}, tp_rd.size(), 48 * k * k);
      chk({tag, "_tap_errs"}, errs, 0);
      chk({tag, "_wr_count"}, wr_a.size(), 48);
      chk({tag, "_wr_errs"}, werr, 0);
      chk({tag, "_extra_rd"}, extra_rd, 0);
   endtask

   initial begin
      int t1_exp[9] = '{0, 3, 6, 12, 15, 18, 24, 27, 30};
      int t2_exp[9] = '{2, 5, 8, 14, 17, 20, 26, 29, 32};
      int d0, b, nr, pads, rerr, i;

      repeat (3) @(negedge clk);
      check_zero("reset");
      rst = 1'b0;

      // T1 + T3: 3x3 frame, stall on tap 4 of the first window
      stall_idx = 4;
      start_frame(2'd0);
      wait_done("t1", 20000);
      verify_frame("t1", 3);
      b = 15 * 9;
      for (int t = 0; t < 9; t++) begin
         chk("t1_rd_addr", tp_rd[b + t], t1_exp[t]);
         chk("t1_pix", tp_pix[b + t], t1_exp[t]);
         chk("t1_idx", tp_idx[b + t], t);
         chk("t1_last", tp_last[b + t], (t == 8) ? 1 : 0);
      end
      chk("t3_stall_cycles", stall_seen, 5);
      chk("t3_stable_errs", stab_err, 0);

      // T2 + T6: 5x5 frame, start pulse while busy and a stray result mid-window
      start_frame(2'd1);
      repeat (50) @(negedge clk);
      ksize_sel = 2'd2; start = 1'b1; stray_arm = 1;
      @(negedge clk);
      start = 1'b0;
      d0 = done_cnt;
      wait_done("t2", 20000);
      verify_frame("t2", 5);
      b = 2 * 25; nr = 0; pads = 0; rerr = 0;
      for (int t = 0; t < 25; t++) begin
         if (tp_rd[b + t] == -1) begin
            if (tp_pix[b + t] == 0) pads++;
         end else begin
            if (nr < 9 && tp_rd[b + t] != t2_exp[nr]) rerr++;
            nr++;
         end
      end
      chk("t2_pads", pads, 16);
      chk("t2_reads", nr, 9);
      chk("t2_read_addr_errs", rerr, 0);
      chk("t6_stray_fired", stray_cnt + stray_arm, 0);
      repeat (20) @(negedge clk);
      chk("t6_single_frame", done_cnt - d0, 1);
      chk("t6_idle_after", busy, 0);

      // T4: 7x7 full frame, done timing
      d0 = done_cnt;
      start_frame(2'd2);
      wait_done("t4", 30000);
      verify_frame("t4", 7);
      chk("t4_done_latency", done_cyc - last_wr_cyc, 1);
      chk("t4_busy_at_done", busy_at_done, 0);
      repeat (5) @(negedge clk);
      chk("t4_done_once", done_cnt - d0, 1);
      chk("t4_busy_low", busy, 0);

      // T5: reset while waiting on the result of sample 10
      rst_arm = 10; rst_trig = 0;
      start_frame(2'd0);
      i = 0;
      while (rst_trig == 0 && i < 5000) begin @(negedge clk); i++; end
      chk("t5_reached_sample10", rst_trig, 1);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      rst_arm = -1;
      check_zero("t5_after_rst");
      chk("t5_writes_before_rst", wr_a.size(), 10);
      d0 = done_cnt;
      repeat (20) @(negedge clk);
      chk("t5_no_done", done_cnt - d0, 0);
      start_frame(2'd0);
      wait_done("t5_rerun", 20000);
      chk("t5_first_wr_addr", (wr_a.size() > 0) ? wr_a[0] : -1, 0);
      verify_frame("t5", 3);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
